// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sequencing byte transfers from NREQ requesters onto one spi_master.
// Latency: req to spi_start 3 cycles (IDLE, GRANT, START); spi_busy fall to ack 1 cycle.
// Backpressure: requesters hold req until ack; a locked owner keeps the grant up to MAX_BURST bytes.
module spi_master_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16,
    parameter int START_TMO = 8,
    parameter int XFER_TMO  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*8-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic [7:0]        rdata,
    output logic              spi_start,
    output logic [7:0]        spi_data_in,
    input  logic              spi_busy,
    input  logic [7:0]        spi_data_out
);

    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMAX = (XFER_TMO > START_TMO) ? XFER_TMO : START_TMO;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_HI, WAIT_LO, ACK} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            tmo_q, tmo_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [7:0]      sdi_q, sdi_d;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [BW-1:0]   burst_inc;

    function automatic logic [IW-1:0] wrap_idx(input int v);
        return IW'(v % NREQ);
    endfunction

    // Walk from the farthest candidate back to ptr so the nearest set request wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(ptr_q) + k)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_idx(int'(ptr_q) + k);
            end
        end
    end

    assign burst_inc = burst_q + 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        timer_d = timer_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        sdi_d   = sdi_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = NREQ'(1) << pick_idx;
                    idx_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                sdi_d   = wdata[{idx_q, 3'b000} +: 8];
                state_d = START;
            end
            START: begin
                timer_d = '0;
                tmo_d   = 1'b0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (spi_busy) begin
                    timer_d = '0;
                    state_d = WAIT_LO;
                end else if (timer_q == TW'(START_TMO - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!spi_busy) begin
                    rdata_d = spi_data_out;
                    state_d = ACK;
                end else if (timer_q == TW'(XFER_TMO - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ACK: begin
                // A timed-out byte never extends the burst, whatever lock says.
                if (!tmo_q && lock[idx_q] && req[idx_q] && (burst_inc < BW'(MAX_BURST))) begin
                    burst_d = burst_inc;
                    state_d = GRANT;
                end else begin
                    gnt_d   = '0;
                    burst_d = '0;
                    ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            timer_q <= '0;
            tmo_q   <= 1'b0;
            rdata_q <= '0;
            sdi_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            timer_q <= timer_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            sdi_q   <= sdi_d;
        end
    end

    assign gnt         = gnt_q;
    assign ack         = (state_q == ACK) ? gnt_q : '0;
    assign err         = (state_q == ACK) && tmo_q;
    assign rdata       = rdata_q;
    assign spi_start   = (state_q == START);
    assign spi_data_in = sdi_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a behavioural spi_master stand-in.
module tb_spi_master_arbiter;

    localparam int NREQ      = 4;
    localparam int MAX_BURST = 16;
    localparam int START_TMO = 8;
    localparam int XFER_TMO  = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, lock;
    logic [31:0] wdata;
    logic [3:0]  gnt, ack;
    logic        err;
    logic [7:0]  rdata;
    logic        spi_start;
    logic [7:0]  spi_data_in;
    logic        spi_busy;
    logic [7:0]  spi_data_out;

    always #5 clk = ~clk;

    spi_master_arbiter #(
        .NREQ(NREQ), .MAX_BURST(MAX_BURST), .START_TMO(START_TMO), .XFER_TMO(XFER_TMO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .wdata(wdata),
        .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
        .spi_start(spi_start), .spi_data_in(spi_data_in),
        .spi_busy(spi_busy), .spi_data_out(spi_data_out)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int inv_viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // spi_master stand-in: busy rises the cycle after start, falls after xfer_len cycles,
    // replying with the sent byte xor slave_xor.
    bit         model_en = 1'b1;
    logic [7:0] slave_xor = 8'h00;
    int         xfer_len = 4;
    logic [7:0] last_sent;
    int         fall_cyc;

    initial begin
        int phase;
        int cnt;
        phase = 0;
        cnt = 0;
        spi_busy = 1'b0;
        spi_data_out = 8'h00;
        last_sent = 8'h00;
        fall_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst !== 1'b1) begin
                spi_busy = 1'b0;
                phase = 0;
            end else begin
                case (phase)
                    0: if (spi_start && model_en) begin
                        last_sent = spi_data_in;
                        phase = 1;
                    end
                    1: begin
                        spi_busy = 1'b1;
                        cnt = 0;
                        phase = 2;
                    end
                    default: begin
                        cnt++;
                        if (cnt >= xfer_len) begin
                            spi_busy = 1'b0;
                            spi_data_out = last_sent ^ slave_xor;
                            fall_cyc = cyc;
                            phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!$onehot0(gnt) || ((ack & ~gnt) != 4'b0000)) inv_viol++;
        if (rst === 1'b0 && spi_start) inv_viol++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output logic [3:0] a, output logic [3:0] g, output logic e,
                            output logic [7:0] d, output int at);
        a = 4'b0000; g = 4'b0000; e = 1'b0; d = 8'h00; at = -1;
        for (int n = 0; n < 2000; n++) begin
            tick();
            if (ack != 4'b0000) begin
                a = ack; g = gnt; e = err; d = rdata; at = cyc;
                return;
            end
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [7:0]  sx;
        logic [3:0]  exp_ack;
        logic [7:0]  exp_sent;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [3:0] a, g, other;
        logic       e;
        logic [7:0] d;
        int         at, st, n2, extra;
        bit         done;

        // Round-robin from ptr=0 with all requesters, then sparse patterns that depend on ptr.
        vt[0] = '{4'b1111, 32'h44332211, 8'h5A, 4'b0001, 8'h11, 8'h4B};
        vt[1] = '{4'b1111, 32'h44332211, 8'h5A, 4'b0010, 8'h22, 8'h78};
        vt[2] = '{4'b1111, 32'h44332211, 8'h5A, 4'b0100, 8'h33, 8'h69};
        vt[3] = '{4'b1111, 32'h44332211, 8'h5A, 4'b1000, 8'h44, 8'h1E};
        vt[4] = '{4'b1111, 32'h44332211, 8'h5A, 4'b0001, 8'h11, 8'h4B};
        vt[5] = '{4'b1001, 32'hC300000F, 8'hFF, 4'b1000, 8'hC3, 8'h3C};
        vt[6] = '{4'b0110, 32'h009AB700, 8'h00, 4'b0010, 8'hB7, 8'hB7};
        vt[7] = '{4'b0011, 32'h0000E17E, 8'h81, 4'b0001, 8'h7E, 8'hFF};

        rst = 1'b0; req = 4'b0000; lock = 4'b0000; wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_gnt", gnt, 4'b0000);
        chk("reset_ack", ack, 4'b0000);
        chk("reset_err", err, 1'b0);
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_spi_start", spi_start, 1'b0);
        chk("reset_spi_data_in", spi_data_in, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            req = vt[i].req;
            wdata = vt[i].wdata;
            slave_xor = vt[i].sx;
            wait_ack(a, g, e, d, at);
            chk($sformatf("vec%0d_ack", i), a, vt[i].exp_ack);
            chk($sformatf("vec%0d_err", i), e, 1'b0);
            chk($sformatf("vec%0d_sent", i), last_sent, vt[i].exp_sent);
            chk($sformatf("vec%0d_rdata", i), d, vt[i].exp_rdata);
        end
        req = 4'b0000;
        tick();

        // Single request: grant one cycle after req is seen, spi_start one cycle later.
        req = 4'b0001; wdata = 32'h00000012; slave_xor = 8'hB7;
        tick();
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_no_early_start", spi_start, 1'b0);
        tick();
        chk("t1_start_latency", spi_start, 1'b1);
        chk("t1_spi_data_in", spi_data_in, 8'h12);
        tick();
        chk("t1_start_one_cycle", spi_start, 1'b0);
        wait_ack(a, g, e, d, at);
        req = 4'b0000;
        chk("t1_ack", a, 4'b0001);
        chk("t1_rdata", d, 8'hA5);
        chk("t1_err", e, 1'b0);
        chk("t1_busy_fall_to_ack", at - fall_cyc, 1);
        tick();
        chk("t1_ack_pulse", ack, 4'b0000);
        chk("t1_released", gnt, 4'b0000);

        // Locked burst by requester 2 (ptr=1): new wdata each byte, forced release after MAX_BURST.
        req = 4'b0100; lock = 4'b0100; slave_xor = 8'h0F;
        wdata = 32'h0080_5C00;
        n2 = 0; done = 1'b0; other = 4'b0000;
        for (int b = 0; b < MAX_BURST + 4 && !done; b++) begin
            wait_ack(a, g, e, d, at);
            if (a == 4'b0100) begin
                chk($sformatf("burst_sent%0d", n2), last_sent, 32'h80 + n2);
                n2++;
                wdata[23:16] = 8'h80 + 8'(n2);
                if (n2 == 1) req = 4'b0110;
            end else begin
                other = a;
                done = 1'b1;
            end
        end
        req = 4'b0000; lock = 4'b0000;
        chk("burst_len", n2, MAX_BURST);
        chk("burst_next_ack", other, 4'b0010);
        chk("burst_next_rdata", d, 8'h53);

        // Busy never rises: timeout after START cycle plus START_TMO cycles in WAIT_HI.
        model_en = 1'b0;
        req = 4'b0001; lock = 4'b0001; wdata[7:0] = 8'h66;
        st = -100;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (spi_start) begin
                st = cyc;
                break;
            end
        end
        wait_ack(a, g, e, d, at);
        chk("tmo_ack", a, 4'b0001);
        chk("tmo_err", e, 1'b1);
        chk("tmo_rdata_kept", d, 8'h53);
        chk("tmo_latency", at - st, START_TMO + 1);
        tick();
        chk("tmo_release_despite_lock", gnt, 4'b0000);
        req = 4'b0000; lock = 4'b0000; model_en = 1'b1;
        tick();

        // Reset during WAIT_LO, then arbitration restarts from ptr=0.
        xfer_len = 30;
        req = 4'b0100; wdata[23:16] = 8'hAA;
        for (int n = 0; n < 20 && !spi_busy; n++) tick();
        repeat (3) tick();
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;
        #1;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_spi_start", spi_start, 1'b0);
        chk("rst_spi_data_in", spi_data_in, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        xfer_len = 4;
        tick();
        req = 4'b0011; wdata = 32'h0000_0201;
        wait_ack(a, g, e, d, at);
        req = 4'b1000;
        chk("rst_ptr_restart", a, 4'b0001);
        wait_ack(a, g, e, d, at);
        req = 4'b0000;
        chk("rst_req3_gnt", g, 4'b1000);
        chk("rst_req3_ack", a, 4'b1000);

        // Requester 1 drops req a cycle after grant; the byte still completes once.
        tick();
        req = 4'b0010; wdata[15:8] = 8'h3C; slave_xor = 8'h00;
        for (int n = 0; n < 10 && gnt != 4'b0010; n++) tick();
        tick();
        req = 4'b0000;
        wait_ack(a, g, e, d, at);
        chk("drop_ack", a, 4'b0010);
        chk("drop_rdata", d, 8'h3C);
        extra = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (ack != 4'b0000) extra++;
        end
        chk("drop_single_ack", extra, 0);
        chk("drop_idle_gnt", gnt, 4'b0000);

        chk("onehot_invariant", inv_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
